busmux_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one two-register-style bus target (write enable, 8-bit address, write data, registered read data with one-cycle latency) among `NREQ` requesters. Each requester issues single read or write transactions with a req/ack handshake. The arbiter latches the winning request and drives the target's bus for exactly one issue cycle. For reads, it waits out the target's read latency and returns the captured data with the ack. It sits between the bus masters and the register block it feeds.

---
 rtl/busmux_arb.sv | 179 +++++++++++++++++
 tb/tb_busmux_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/busmux_arb.sv
// busmux_arb: shares one register-style bus target among NREQ requesters.
//
// A winner is picked in IDLE, its write flag, address and write data are
// latched, and the target bus is driven for a single ISSUE cycle. Reads wait
// one extra cycle for the target's registered read data and return it with
// the ack.
//
// Build option: define BUSMUX_ARB_RR_EN for round-robin arbitration. When it
// is undefined, arbitration is fixed priority (lowest index wins) and no
// last-grant pointer exists. Timing and handshake are the same either way.
//
// Ports:
//   i_clk, i_rst_n  clock (rising edge), asynchronous active-low reset
//   i_req, i_we     per-requester request and write(1)/read(0) flag
//   i_addr          per-requester 8-bit address, requester k at [8k+7:8k]
//   i_wdata         per-requester write data, packed like i_addr
//   o_ack           one-cycle completion pulse to the owning requester
//   o_gnt           one-hot owner, high from ISSUE through DONE
//   o_rdata         read data, valid while o_ack is high for a read
//   o_reg_we, o_reg_addr, o_reg_data  target bus
//   i_reg_data      target registered read data (one-cycle latency)
module busmux_arb #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned DATAW = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ-1:0]         i_we,
    input  logic [NREQ*8-1:0]       i_addr,
    input  logic [NREQ*DATAW-1:0]   i_wdata,
    output logic [NREQ-1:0]         o_ack,
    output logic [NREQ-1:0]         o_gnt,
    output logic [DATAW-1:0]        o_rdata,
    output logic                    o_reg_we,
    output logic [7:0]              o_reg_addr,
    output logic [DATAW-1:0]        o_reg_data,
    input  logic [DATAW-1:0]        i_reg_data
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               we_q, we_d;
    logic [7:0]         addr_q, addr_d;
    logic [DATAW-1:0]   wdata_q, wdata_d;
    logic [DATAW-1:0]   rdata_q, rdata_d;

    logic               win_valid;
    logic [PtrW-1:0]    win_idx;
    logic [PtrW-1:0]    cand;
    logic [PtrW-1:0]    search_start;
    logic [NREQ-1:0]    win_onehot;
    logic               sel_we;
    logic [7:0]         sel_addr;
    logic [DATAW-1:0]   sel_wdata;

`ifdef BUSMUX_ARB_RR_EN
    logic [PtrW-1:0]    last_q, last_d;
    assign search_start = last_q;
`else
    // Starting "after" the top index makes the scan begin at 0: fixed priority.
    assign search_start = PtrW'(NREQ - 1);
`endif

    // Scan starting one past search_start, wrapping modulo NREQ; first hit wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = search_start;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (cand == PtrW'(NREQ - 1)) ? '0 : cand + PtrW'(1);
            if (!win_valid && i_req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Mux out the winner's fields and build its one-hot grant.
    always_comb begin
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        win_onehot = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (win_idx == PtrW'(k)) begin
                sel_we        = i_we[k];
                sel_addr      = i_addr[k*8 +: 8];
                sel_wdata     = i_wdata[k*DATAW +: DATAW];
                win_onehot[k] = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (win_valid) state_d = StIssue;
            StIssue: state_d = we_q ? StDone : StWait;
            StWait:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: latch on grant, capture read data in WAIT.
    always_comb begin
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef BUSMUX_ARB_RR_EN
        last_d  = last_q;
`endif
        if (state_q == StIdle && win_valid) begin
            gnt_d   = win_onehot;
            we_d    = sel_we;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
`ifdef BUSMUX_ARB_RR_EN
            last_d  = win_idx;
`endif
        end
        if (state_q == StWait) begin
            rdata_d = i_reg_data;
        end
        if (state_q == StDone) begin
            gnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef BUSMUX_ARB_RR_EN
            last_q  <= PtrW'(NREQ - 1);
`endif
        end else begin
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef BUSMUX_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Outputs decoded from registered state only; reset clears them at once.
    always_comb begin
        o_reg_we   = (state_q == StIssue) & we_q;
        o_ack      = (state_q == StDone) ? gnt_q : '0;
        o_gnt      = gnt_q;
        o_reg_addr = addr_q;
        o_reg_data = wdata_q;
        o_rdata    = rdata_q;
    end

endmodule

// File: tb/tb_busmux_arb.sv
module tb_busmux_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // NREQ=2 instance
    logic [1:0]  req, we, ack, gnt;
    logic [15:0] addr, wdata;
    logic [7:0]  rdata, reg_addr, reg_data, reg_rdata;
    logic        reg_we;

    // NREQ=4 instance
    logic [3:0]  req4, we4, ack4, gnt4;
    logic [31:0] addr4, wdata4;
    logic [7:0]  rdata4, reg_addr4, reg_data4, reg_rdata4;
    logic        reg_we4;

    int errors = 0;
    int checks = 0;

    busmux_arb #(.NREQ(2), .DATAW(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .o_ack(ack), .o_gnt(gnt), .o_rdata(rdata), .o_reg_we(reg_we),
        .o_reg_addr(reg_addr), .o_reg_data(reg_data), .i_reg_data(reg_rdata)
    );

    busmux_arb #(.NREQ(4), .DATAW(8)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req4), .i_we(we4), .i_addr(addr4),
        .i_wdata(wdata4), .o_ack(ack4), .o_gnt(gnt4), .o_rdata(rdata4), .o_reg_we(reg_we4),
        .o_reg_addr(reg_addr4), .o_reg_data(reg_data4), .i_reg_data(reg_rdata4)
    );

    // Register-block targets: write on we, registered read with one-cycle latency.
    logic [7:0] mem [256];
    logic [7:0] mem4 [256];
    always @(posedge clk) begin
        if (reg_we) mem[reg_addr] <= reg_data;
        reg_rdata <= mem[reg_addr];
        if (reg_we4) mem4[reg_addr4] <= reg_data4;
        reg_rdata4 <= mem4[reg_addr4];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input int k, input logic w, input logic [7:0] a, input logic [7:0] d);
        req[k] = 1'b1;
        we[k] = w;
        addr[k*8 +: 8] = a;
        wdata[k*8 +: 8] = d;
    endtask

    task automatic drive4(input int k, input logic w, input logic [7:0] a, input logic [7:0] d);
        req4[k] = 1'b1;
        we4[k] = w;
        addr4[k*8 +: 8] = a;
        wdata4[k*8 +: 8] = d;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (gnt !== 2'b00 || ack !== 2'b00) begin errors++;
            $display("FAIL reset_gnt_ack: got gnt=%b ack=%b want 00 00", gnt, ack); end
        checks++; if (reg_we !== 1'b0 || reg_addr !== 8'h00 || reg_data !== 8'h00
                      || rdata !== 8'h00) begin errors++;
            $display("FAIL reset_bus: got we=%b addr=%h data=%h rdata=%h want all 0",
                     reg_we, reg_addr, reg_data, rdata); end
        checks++; if (gnt4 !== 4'h0 || ack4 !== 4'h0 || reg_we4 !== 1'b0) begin errors++;
            $display("FAIL reset_nreq4: got gnt=%b ack=%b we=%b want 0", gnt4, ack4, reg_we4); end
        rst_n = 1'b1;
        tick();
        checks++; if (gnt !== 2'b00) begin errors++;
            $display("FAIL reset_idle_gnt: got %b want 00", gnt); end
    endtask

    task automatic test_single_write();
        drive2(0, 1'b1, 8'h01, 8'hA5);
        checks++; if (reg_we !== 1'b0) begin errors++;
            $display("FAIL write_idle_we: got %b want 0", reg_we); end
        tick(); // ISSUE
        checks++; if (reg_we !== 1'b1 || reg_addr !== 8'h01 || reg_data !== 8'hA5) begin errors++;
            $display("FAIL write_issue: got we=%b addr=%h data=%h want 1 01 a5",
                     reg_we, reg_addr, reg_data); end
        checks++; if (gnt !== 2'b01 || ack !== 2'b00) begin errors++;
            $display("FAIL write_issue_gnt: got gnt=%b ack=%b want 01 00", gnt, ack); end
        tick(); // DONE
        checks++; if (ack !== 2'b01 || reg_we !== 1'b0 || gnt !== 2'b01) begin errors++;
            $display("FAIL write_ack: got ack=%b we=%b gnt=%b want 01 0 01", ack, reg_we, gnt); end
        req = 2'b00;
        tick(); // IDLE
        checks++; if (ack !== 2'b00 || gnt !== 2'b00) begin errors++;
            $display("FAIL write_after: got ack=%b gnt=%b want 00 00", ack, gnt); end
    endtask

    task automatic test_read_back();
        drive2(1, 1'b0, 8'h01, 8'h00);
        tick(); // ISSUE
        checks++; if (reg_we !== 1'b0 || gnt !== 2'b10 || reg_addr !== 8'h01) begin errors++;
            $display("FAIL read_issue: got we=%b gnt=%b addr=%h want 0 10 01",
                     reg_we, gnt, reg_addr); end
        tick(); // WAIT
        checks++; if (reg_we !== 1'b0 || ack !== 2'b00 || reg_addr !== 8'h01) begin errors++;
            $display("FAIL read_wait: got we=%b ack=%b addr=%h want 0 00 01",
                     reg_we, ack, reg_addr); end
        tick(); // DONE
        checks++; if (ack !== 2'b10 || rdata !== 8'hA5 || reg_we !== 1'b0) begin errors++;
            $display("FAIL read_ack: got ack=%b rdata=%h we=%b want 10 a5 0", ack, rdata, reg_we); end
        req = 2'b00;
        tick();
        checks++; if (ack !== 2'b00 || rdata !== 8'hA5) begin errors++;
            $display("FAIL read_hold: got ack=%b rdata=%h want 00 a5", ack, rdata); end
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        drive2(0, 1'b1, 8'h10, 8'h11);
        drive2(1, 1'b1, 8'h11, 8'h22);
        for (int i = 0; i < 4; i++) begin
`ifdef BUSMUX_ARB_RR_EN
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp = 2'b01;
`endif
            tick(); // ISSUE
            tick(); // DONE
            checks++; if (ack !== exp) begin errors++;
                $display("FAIL contention_ack%0d: got %b want %b", i, ack, exp); end
            if (i == 3) req = 2'b00;
            tick(); // IDLE
        end
        checks++; if (gnt !== 2'b00) begin errors++;
            $display("FAIL contention_end_gnt: got %b want 00", gnt); end
    endtask

    task automatic test_early_drop();
        drive2(0, 1'b1, 8'h20, 8'h3C);
        tick(); // ISSUE
        req = 2'b00;
        checks++; if (reg_we !== 1'b1 || gnt !== 2'b01) begin errors++;
            $display("FAIL drop_issue: got we=%b gnt=%b want 1 01", reg_we, gnt); end
        tick(); // DONE
        checks++; if (ack !== 2'b01) begin errors++;
            $display("FAIL drop_ack: got %b want 01", ack); end
        tick();
        tick();
        checks++; if (ack !== 2'b00 || gnt !== 2'b00 || reg_we !== 1'b0) begin errors++;
            $display("FAIL drop_idle: got ack=%b gnt=%b we=%b want 00 00 0", ack, gnt, reg_we); end
    endtask

    task automatic test_reset_abort();
        drive2(0, 1'b0, 8'h20, 8'h3C);
        tick(); // ISSUE
        tick(); // WAIT
        checks++; if (gnt !== 2'b01 || reg_addr !== 8'h20) begin errors++;
            $display("FAIL abort_wait: got gnt=%b addr=%h want 01 20", gnt, reg_addr); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 2'b00 || ack !== 2'b00 || reg_we !== 1'b0) begin errors++;
            $display("FAIL abort_ctrl: got gnt=%b ack=%b we=%b want 00 00 0", gnt, ack, reg_we); end
        checks++; if (rdata !== 8'h00 || reg_addr !== 8'h00 || reg_data !== 8'h00) begin errors++;
            $display("FAIL abort_data: got rdata=%h addr=%h data=%h want 00 00 00",
                     rdata, reg_addr, reg_data); end
        req = 2'b00;
        tick();
        checks++; if (ack !== 2'b00) begin errors++;
            $display("FAIL abort_no_ack: got %b want 00", ack); end
        #2 rst_n = 1'b1;
        tick();
        checks++; if (ack !== 2'b00 || gnt !== 2'b00) begin errors++;
            $display("FAIL abort_release: got ack=%b gnt=%b want 00 00", ack, gnt); end
        drive2(0, 1'b0, 8'h20, 8'h00);
        drive2(1, 1'b1, 8'h40, 8'h55);
        tick(); // ISSUE
        checks++; if (gnt !== 2'b01) begin errors++;
            $display("FAIL abort_first_gnt: got %b want 01", gnt); end
        req = 2'b00;
        tick(); // WAIT
        tick(); // DONE
        checks++; if (ack !== 2'b01 || rdata !== 8'h3C) begin errors++;
            $display("FAIL abort_after_read: got ack=%b rdata=%h want 01 3c", ack, rdata); end
        tick();
    endtask

    task automatic test_boundary_nreq4();
        logic [3:0] exp;
        drive4(3, 1'b1, 8'h30, 8'h77);
        tick(); // ISSUE
        checks++; if (gnt4 !== 4'b1000 || reg_we4 !== 1'b1) begin errors++;
            $display("FAIL n4_gnt3: got gnt=%b we=%b want 1000 1", gnt4, reg_we4); end
        tick(); // DONE
        checks++; if (ack4 !== 4'b1000 || gnt4 !== 4'b1000) begin errors++;
            $display("FAIL n4_ack3: got ack=%b gnt=%b want 1000 1000", ack4, gnt4); end
        req4 = 4'h0;
        tick();
        checks++; if (gnt4 !== 4'h0) begin errors++;
            $display("FAIL n4_idle_gnt: got %b want 0000", gnt4); end
        drive4(0, 1'b0, 8'h30, 8'h00);
        tick(); // ISSUE
        checks++; if (gnt4 !== 4'b0001) begin errors++;
            $display("FAIL n4_wrap_issue: got %b want 0001", gnt4); end
        tick(); // WAIT
        checks++; if (gnt4 !== 4'b0001 || reg_we4 !== 1'b0) begin errors++;
            $display("FAIL n4_wrap_wait: got gnt=%b we=%b want 0001 0", gnt4, reg_we4); end
        tick(); // DONE
        checks++; if (ack4 !== 4'b0001 || gnt4 !== 4'b0001 || rdata4 !== 8'h77) begin errors++;
            $display("FAIL n4_wrap_done: got ack=%b gnt=%b rdata=%h want 0001 0001 77",
                     ack4, gnt4, rdata4); end
        req4 = 4'h0;
        tick();
        checks++; if (gnt4 !== 4'h0 || ack4 !== 4'h0) begin errors++;
            $display("FAIL n4_idle2: got gnt=%b ack=%b want 0000 0000", gnt4, ack4); end
        // Requesters 0 and 3 together, last grant was 0.
        drive4(0, 1'b1, 8'h31, 8'h01);
        drive4(3, 1'b1, 8'h32, 8'h02);
`ifdef BUSMUX_ARB_RR_EN
        exp = 4'b1000;
`else
        exp = 4'b0001;
`endif
        tick(); // ISSUE
        req4 = 4'h0;
        checks++; if (gnt4 !== exp) begin errors++;
            $display("FAIL n4_pair_gnt: got %b want %b", gnt4, exp); end
        tick(); // DONE
        checks++; if (ack4 !== exp) begin errors++;
            $display("FAIL n4_pair_ack: got %b want %b", ack4, exp); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0;
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_early_drop();
        test_reset_abort();
        test_boundary_nreq4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
